// File: rtl/vrp_rr_arb.sv
// Round-robin N:1 valid/ready arbiter with packet lock; multi-beat packets hold the grant until last.
// Optional 2-entry skid FIFO on the master side when VRP_RR_ARB_OUT_REG_EN is defined.
module vrp_rr_arb #(
  parameter int WIDTH     = 8,
  parameter int PLD_WIDTH = 32,
  localparam int IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     v_vld_s,
  input  logic [PLD_WIDTH-1:0] v_pld_s [WIDTH-1:0],
  input  logic [WIDTH-1:0]     v_last_s,
  output logic [WIDTH-1:0]     v_rdy_s,
  input  logic                 rdy_m,
  output logic                 vld_m,
  output logic [PLD_WIDTH-1:0] pld_m,
  output logic                 last_m,
  output logic [IDX_W-1:0]     idx_m
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lockIdx_q, lockIdx_d;

  logic [IDX_W-1:0] grantIdx;
  logic             grantVld;
  logic             grantLast;
  logic             arbVld;
  logic             intRdy;
  logic             xfer;

  // Locked: only the packet owner may proceed. Unlocked: first valid searching cyclically from ptr.
  always_comb begin
    int j;
    j        = 0;
    grantIdx = '0;
    grantVld = 1'b0;
    if (lock_q) begin
      grantIdx = lockIdx_q;
      grantVld = v_vld_s[lockIdx_q];
    end else begin
      for (int k = WIDTH - 1; k >= 0; k--) begin
        j = int'(ptr_q) + k;
        if (j >= WIDTH) j = j - WIDTH;
        if (v_vld_s[IDX_W'(j)]) begin
          grantVld = 1'b1;
          grantIdx = IDX_W'(j);
        end
      end
    end
  end

  assign grantLast = v_last_s[grantIdx];
  assign arbVld    = grantVld && !rst;
  assign xfer      = arbVld && intRdy;

  always_comb begin
    v_rdy_s = '0;
    if (xfer) v_rdy_s[grantIdx] = 1'b1;
  end

  always_comb begin
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    lockIdx_d = lockIdx_q;
    if (xfer) begin
      if (grantLast) begin
        lock_d = 1'b0;
        ptr_d  = (grantIdx == IDX_W'(WIDTH - 1)) ? '0 : grantIdx + 1'b1;
      end else begin
        lock_d    = 1'b1;
        lockIdx_d = grantIdx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lockIdx_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lockIdx_q <= lockIdx_d;
    end
  end

`ifdef VRP_RR_ARB_OUT_REG_EN
  localparam int ENT_W = IDX_W + 1 + PLD_WIDTH;

  logic [ENT_W-1:0] ent0_q, ent0_d;
  logic [ENT_W-1:0] ent1_q, ent1_d;
  logic [1:0]       count_q, count_d;
  logic [ENT_W-1:0] pushEnt;
  logic             push;
  logic             pop;

  // Ready depends only on registered occupancy, so rdy_m never reaches v_rdy_s combinationally.
  assign intRdy  = (count_q < 2'd2);
  assign pushEnt = {grantIdx, grantLast, v_pld_s[grantIdx]};
  assign push    = xfer;
  assign vld_m   = (count_q != 2'd0) && !rst;
  assign pop     = vld_m && rdy_m;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) ent0_d = pushEnt;
        else                 ent1_d = pushEnt;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          ent0_d = pushEnt;
        end else begin
          ent0_d = ent1_q;
          ent1_d = pushEnt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= '0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign idx_m  = vld_m ? ent0_q[ENT_W-1 -: IDX_W] : '0;
  assign last_m = vld_m ? ent0_q[PLD_WIDTH]        : 1'b0;
  assign pld_m  = vld_m ? ent0_q[PLD_WIDTH-1:0]    : '0;
`else
  assign intRdy = rdy_m;
  assign vld_m  = arbVld;
  assign idx_m  = arbVld ? grantIdx           : '0;
  assign last_m = arbVld ? grantLast          : 1'b0;
  assign pld_m  = arbVld ? v_pld_s[grantIdx]  : '0;
`endif

endmodule

// File: tb/tb_vrp_rr_arb.sv
// Directed self-checking bench for vrp_rr_arb with WIDTH=4 in the combinational-output build.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_vrp_rr_arb;

  localparam int W  = 4;
  localparam int PW = 8;

  logic          clk;
  logic          rst;
  logic [W-1:0]  vVld;
  logic [PW-1:0] vPld [W-1:0];
  logic [W-1:0]  vLast;
  logic [W-1:0]  vRdy;
  logic          rdyM;
  logic          vldM;
  logic [PW-1:0] pldM;
  logic          lastM;
  logic [1:0]    idxM;

  int checks;
  int failures;

  vrp_rr_arb #(.WIDTH(W), .PLD_WIDTH(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .v_vld_s  (vVld),
    .v_pld_s  (vPld),
    .v_last_s (vLast),
    .v_rdy_s  (vRdy),
    .rdy_m    (rdyM),
    .vld_m    (vldM),
    .pld_m    (pldM),
    .last_m   (lastM),
    .idx_m    (idxM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    vVld  = '0;
    vLast = '1;
    rdyM  = 1'b1;
    for (int i = 0; i < W; i++) vPld[i] = 8'hA0 + 8'(i);
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearInputs();
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clearInputs();
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      #1;
      checks++;
      if (vldM !== 1'b0) begin failures++; $display("[TB] FAIL reset_vld cycle %0d: got %b want 0", c, vldM); end
      checks++;
      if (vRdy !== 4'b0000) begin failures++; $display("[TB] FAIL reset_rdy cycle %0d: got %b want 0000", c, vRdy); end
    end
    vVld = 4'b1111;
    #1;
    checks++;
    if (vldM !== 1'b0) begin failures++; $display("[TB] FAIL reset_cycle_vld: got %b want 0", vldM); end
    checks++;
    if (vRdy !== 4'b0000) begin failures++; $display("[TB] FAIL reset_cycle_rdy: got %b want 0000", vRdy); end
    nextCycle();
    rst = 1'b0;
    #1;
    checks++;
    if (vldM !== 1'b1 || idxM !== 2'd0) begin failures++; $display("[TB] FAIL reset_ptr0: got vld=%b idx=%0d want vld=1 idx=0", vldM, idxM); end
    clearInputs();
  endtask

  task automatic test_round_robin();
    logic [1:0] expIdx;
    doReset();
    vVld = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      expIdx = 2'(c % 4);
      #1;
      checks++;
      if (vldM !== 1'b1 || idxM !== expIdx) begin failures++; $display("[TB] FAIL rr_idx beat %0d: got vld=%b idx=%0d want vld=1 idx=%0d", c, vldM, idxM, expIdx); end
      checks++;
      if (vRdy !== (4'b0001 << expIdx) || pldM !== (8'hA0 + 8'(expIdx))) begin failures++; $display("[TB] FAIL rr_rdy_pld beat %0d: got rdy=%b pld=%h want rdy=%b pld=%h", c, vRdy, pldM, 4'b0001 << expIdx, 8'hA0 + 8'(expIdx)); end
      nextCycle();
    end
    clearInputs();
  endtask

  task automatic test_packet_lock();
    doReset();
    vVld = 4'b0010;
    #1;
    checks++;
    if (idxM !== 2'd1 || vRdy !== 4'b0010) begin failures++; $display("[TB] FAIL lock_setup: got idx=%0d rdy=%b want idx=1 rdy=0010", idxM, vRdy); end
    nextCycle();
    vVld = 4'b0111;
    for (int b = 0; b < 3; b++) begin
      vLast[2] = (b == 2);
      vPld[2]  = 8'h20 + 8'(b);
      #1;
      checks++;
      if (vldM !== 1'b1 || idxM !== 2'd2 || vRdy !== 4'b0100) begin failures++; $display("[TB] FAIL lock_beat %0d: got vld=%b idx=%0d rdy=%b want vld=1 idx=2 rdy=0100", b, vldM, idxM, vRdy); end
      checks++;
      if (pldM !== (8'h20 + 8'(b)) || lastM !== (b == 2)) begin failures++; $display("[TB] FAIL lock_pld %0d: got pld=%h last=%b want pld=%h last=%b", b, pldM, lastM, 8'h20 + 8'(b), (b == 2)); end
      nextCycle();
    end
    vVld = 4'b0011;
    #1;
    checks++;
    if (idxM !== 2'd0 || vRdy !== 4'b0001) begin failures++; $display("[TB] FAIL lock_after: got idx=%0d rdy=%b want idx=0 rdy=0001", idxM, vRdy); end
    nextCycle();
    clearInputs();
  endtask

  task automatic test_locked_drop();
    doReset();
    vVld     = 4'b0010;
    vLast[1] = 1'b0;
    #1;
    checks++;
    if (idxM !== 2'd1 || lastM !== 1'b0) begin failures++; $display("[TB] FAIL drop_first: got idx=%0d last=%b want idx=1 last=0", idxM, lastM); end
    nextCycle();
    vVld = 4'b1101;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (vldM !== 1'b0 || vRdy !== 4'b0000) begin failures++; $display("[TB] FAIL drop_stall %0d: got vld=%b rdy=%b want vld=0 rdy=0000", c, vldM, vRdy); end
      nextCycle();
    end
    vVld     = 4'b1111;
    vLast[1] = 1'b1;
    #1;
    checks++;
    if (vldM !== 1'b1 || idxM !== 2'd1 || vRdy !== 4'b0010) begin failures++; $display("[TB] FAIL drop_resume: got vld=%b idx=%0d rdy=%b want vld=1 idx=1 rdy=0010", vldM, idxM, vRdy); end
    nextCycle();
    vVld = 4'b1101;
    #1;
    checks++;
    if (idxM !== 2'd2 || vRdy !== 4'b0100) begin failures++; $display("[TB] FAIL drop_next: got idx=%0d rdy=%b want idx=2 rdy=0100", idxM, vRdy); end
    nextCycle();
    clearInputs();
  endtask

  task automatic test_stall();
    doReset();
    vVld    = 4'b0011;
    vPld[0] = 8'h5A;
    rdyM    = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (vldM !== 1'b1 || idxM !== 2'd0 || pldM !== 8'h5A || vRdy !== 4'b0000) begin failures++; $display("[TB] FAIL stall %0d: got vld=%b idx=%0d pld=%h rdy=%b want vld=1 idx=0 pld=5a rdy=0000", c, vldM, idxM, pldM, vRdy); end
      nextCycle();
    end
    rdyM = 1'b1;
    #1;
    checks++;
    if (idxM !== 2'd0 || vRdy !== 4'b0001) begin failures++; $display("[TB] FAIL stall_release: got idx=%0d rdy=%b want idx=0 rdy=0001", idxM, vRdy); end
    nextCycle();
    #1;
    checks++;
    if (idxM !== 2'd1 || vRdy !== 4'b0010) begin failures++; $display("[TB] FAIL stall_next: got idx=%0d rdy=%b want idx=1 rdy=0010", idxM, vRdy); end
    nextCycle();
    clearInputs();
  endtask

  task automatic test_reset_mid_packet();
    doReset();
    vVld     = 4'b1000;
    vLast[3] = 1'b0;
    #1;
    checks++;
    if (idxM !== 2'd3 || vRdy !== 4'b1000) begin failures++; $display("[TB] FAIL rmid_first: got idx=%0d rdy=%b want idx=3 rdy=1000", idxM, vRdy); end
    nextCycle();
    vVld = 4'b1001;
    #1;
    checks++;
    if (idxM !== 2'd3 || vRdy !== 4'b1000) begin failures++; $display("[TB] FAIL rmid_locked: got idx=%0d rdy=%b want idx=3 rdy=1000", idxM, vRdy); end
    nextCycle();
    rst = 1'b1;
    #1;
    checks++;
    if (vldM !== 1'b0 || vRdy !== 4'b0000) begin failures++; $display("[TB] FAIL rmid_rst_cycle: got vld=%b rdy=%b want vld=0 rdy=0000", vldM, vRdy); end
    nextCycle();
    rst = 1'b0;
    #1;
    checks++;
    if (vldM !== 1'b1 || idxM !== 2'd0 || vRdy !== 4'b0001) begin failures++; $display("[TB] FAIL rmid_after: got vld=%b idx=%0d rdy=%b want vld=1 idx=0 rdy=0001", vldM, idxM, vRdy); end
    nextCycle();
    clearInputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clearInputs();
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_locked_drop();
    test_stall();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
